// File: rtl/me_pkg.sv
// me_pkg: default parameter values and the FSM state type shared by the
// motion-estimation search core and its SAD lanes.
package me_pkg;

  localparam int unsigned DefPixW    = 8;
  localparam int unsigned DefRowPix  = 8;
  localparam int unsigned DefBlkRows = 8;
  localparam int unsigned DefNCand   = 16;
  localparam int unsigned DefSearchW = 4;
  localparam int unsigned DefMvW     = 4;
  localparam int unsigned DefSadW    = DefPixW + $clog2(DefRowPix * DefBlkRows);

  typedef enum logic [1:0] {
    StAccum,
    StSearch,
    StDone
  } me_state_e;

endpackage

// File: rtl/me_sad_lane.sv
// me_sad_lane: one candidate lane. Sums |crt - pre| over the pixels of a row
// beat and accumulates the block SAD across beats.
module me_sad_lane
  import me_pkg::*;
#(
  parameter int unsigned PIX_W   = DefPixW,
  parameter int unsigned ROW_PIX = DefRowPix,
  parameter int unsigned SAD_W   = DefSadW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic [ROW_PIX*PIX_W-1:0] i_crt_row,
  input  logic [ROW_PIX*PIX_W-1:0] i_pre_row,
  output logic [SAD_W-1:0]         o_acc
);

  logic [PIX_W-1:0] w_diff [ROW_PIX];
  logic [SAD_W-1:0] w_row_sad;
  logic [SAD_W-1:0] r_acc;

  for (genvar g = 0; g < ROW_PIX; g++) begin : g_pix
    logic [PIX_W-1:0] w_a;
    logic [PIX_W-1:0] w_b;
    assign w_a       = i_crt_row[g*PIX_W +: PIX_W];
    assign w_b       = i_pre_row[g*PIX_W +: PIX_W];
    assign w_diff[g] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  end

  // Row SAD: sum of the per-pixel absolute differences of this beat.
  always_comb begin
    w_row_sad = '0;
    for (int unsigned p = 0; p < ROW_PIX; p++) begin
      w_row_sad = w_row_sad + SAD_W'(w_diff[p]);
    end
  end

  // Block accumulator: cleared on reset or result hand-off, grows on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_row_sad;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/me_search_core.sv
// me_search_core: block-matching motion search. Accumulates per-candidate SAD
// over BLK_ROWS row beats, then scans the candidates one per cycle for the
// minimum (lowest index wins ties) and presents SAD and motion vector.
// Optional ME_EARLY_TERM_EN: a zero-SAD candidate ends the scan immediately.
module me_search_core
  import me_pkg::*;
#(
  parameter int unsigned PIX_W    = DefPixW,
  parameter int unsigned ROW_PIX  = DefRowPix,
  parameter int unsigned BLK_ROWS = DefBlkRows,
  parameter int unsigned N_CAND   = DefNCand,
  parameter int unsigned SEARCH_W = DefSearchW,
  parameter int unsigned MV_W     = DefMvW,
  localparam int unsigned SAD_W   = PIX_W + $clog2(ROW_PIX * BLK_ROWS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROW_PIX*PIX_W-1:0]        crt_row,
  input  logic [N_CAND*ROW_PIX*PIX_W-1:0] pre_rows,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SAD_W-1:0]                sad_min,
  output logic [MV_W-1:0]                 mv_x,
  output logic [MV_W-1:0]                 mv_y
);

  localparam int unsigned RowW  = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam int unsigned IdxW  = $clog2(N_CAND);
  localparam int unsigned LaneW = ROW_PIX * PIX_W;

  me_state_e        r_state;
  logic [RowW-1:0]  r_row;
  logic [IdxW-1:0]  r_idx;
  logic [IdxW-1:0]  r_min_idx;
  logic [SAD_W-1:0] r_min;
  logic             r_scan_done;
  logic             r_out_valid;
  logic [SAD_W-1:0] r_sad_min;
  logic [MV_W-1:0]  r_mv_x;
  logic [MV_W-1:0]  r_mv_y;

  logic             w_acc_en;
  logic             w_acc_clr;
  logic [SAD_W-1:0] w_acc [N_CAND];
  logic [SAD_W-1:0] w_cand;
  logic [31:0]      w_idx_ext;
  logic [MV_W-1:0]  w_mv_x;
  logic [MV_W-1:0]  w_mv_y;

  assign w_acc_en  = (r_state == StAccum) && in_valid;
  assign w_acc_clr = (r_state == StDone) && out_ready;

  for (genvar k = 0; k < N_CAND; k++) begin : g_lane
    me_sad_lane #(
      .PIX_W  (PIX_W),
      .ROW_PIX(ROW_PIX),
      .SAD_W  (SAD_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_acc_en),
      .i_clr    (w_acc_clr),
      .i_crt_row(crt_row),
      .i_pre_row(pre_rows[k*LaneW +: LaneW]),
      .o_acc    (w_acc[k])
    );
  end

  assign w_cand    = w_acc[r_idx];
  assign w_idx_ext = 32'(r_min_idx);
  assign w_mv_x    = MV_W'(w_idx_ext % SEARCH_W);
  assign w_mv_y    = MV_W'(w_idx_ext / SEARCH_W);

  // Control FSM: row counting, candidate scan and registered result hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StAccum;
      r_row       <= '0;
      r_idx       <= '0;
      r_min_idx   <= '0;
      r_min       <= '0;
      r_scan_done <= 1'b0;
      r_out_valid <= 1'b0;
      r_sad_min   <= '0;
      r_mv_x      <= '0;
      r_mv_y      <= '0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (in_valid) begin
            if (r_row == RowW'(BLK_ROWS - 1)) begin
              r_row       <= '0;
              r_idx       <= '0;
              r_scan_done <= 1'b0;
              r_state     <= StSearch;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        StSearch: begin
          if (r_scan_done) begin
            // Extra cycle registers the final minimum into the outputs.
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_sad_min   <= r_min;
            r_mv_x      <= w_mv_x;
            r_mv_y      <= w_mv_y;
          end else begin
            if ((r_idx == '0) || (w_cand < r_min)) begin
              r_min     <= w_cand;
              r_min_idx <= r_idx;
            end
            r_idx <= r_idx + 1'b1;
`ifdef ME_EARLY_TERM_EN
            if ((r_idx == IdxW'(N_CAND - 1)) || (w_cand == '0)) begin
              r_scan_done <= 1'b1;
            end
`else
            if (r_idx == IdxW'(N_CAND - 1)) begin
              r_scan_done <= 1'b1;
            end
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StAccum;
          end
        end
        default: r_state <= StAccum;
      endcase
    end
  end

  assign in_ready  = (r_state == StAccum);
  assign out_valid = r_out_valid;
  assign sad_min   = r_sad_min;
  assign mv_x      = r_mv_x;
  assign mv_y      = r_mv_y;

endmodule
